ad7606_emulator: RTL and testbench

Synthesizable behavioural responder for the AD7606 parallel interface. It stands in for the physical ADC in simulation and on-board loopback builds. It answers CONVST pulses with a BUSY interval scaled by the oversampling setting, then serves eight deterministic 16-bit channel words on successive RD strobes, flagging channel 0 with FRSTDATA. It sits on the same pins and in the same clock domain as the acquisition controller, so the controller and UART path can be exercised without hardware.

---
 rtl/ad7606_emulator.sv | 97 +++++++++
 tb/tb_ad7606_emulator.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ad7606_emulator.sv
// ad7606_emulator: cycle-level stand-in for the AD7606 parallel ADC interface
module ad7606_emulator #(
  parameter int BUSY_BASE = 200,
  parameter int CNT_W     = 13
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [2:0]  ad_os_i,
  input  logic        ad_cs_i,
  input  logic        ad_rd_i,
  input  logic        ad_reset_i,
  input  logic        ad_convstab_i,
  output logic [15:0] ad_data_o,
  output logic        ad_busy_o,
  output logic        first_data_o
);
  typedef enum logic {IDLE, CONV} state_t;
  state_t             state_q;
  logic [13:0]        cnt_q;
  logic [CNT_W-1:0]   conv_idx_q;
  logic [CNT_W-1:0]   active_idx_q;
  logic [2:0]         ptr_q;
  logic               cv_prev_q;
  logic               rd_prev_q;
  logic [15:0]        data_q;
  logic               busy_q;
  logic               first_q;
  logic               rise;
  logic               fall;
  logic               done;
  logic [2:0]         os_eff;
  logic [13:0]        busy_len;
  assign ad_data_o    = data_q;
  assign ad_busy_o    = busy_q;
  assign first_data_o = first_q;
  // Edge detection, terminal count and busy length (os 7 aliases to 0); counter loads N-1 so busy spans N edges
  always_comb begin
    rise     = ad_convstab_i & ~cv_prev_q;
    fall     = rd_prev_q & ~ad_rd_i & ~ad_cs_i;
    done     = (state_q == CONV) && (cnt_q == 14'd0);
    os_eff   = (ad_os_i == 3'd7) ? 3'd0 : ad_os_i;
    busy_len = (14'(BUSY_BASE) << os_eff) - 14'd1;
  end
  // Conversion FSM and readout; conversion end takes priority and serves a coincident read as channel 0
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      conv_idx_q   <= '0;
      active_idx_q <= '0;
      ptr_q        <= '0;
      cv_prev_q    <= 1'b0;
      rd_prev_q    <= 1'b1;
      data_q       <= '0;
      busy_q       <= 1'b0;
      first_q      <= 1'b0;
    end else if (ad_reset_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      conv_idx_q   <= '0;
      active_idx_q <= '0;
      ptr_q        <= '0;
      cv_prev_q    <= 1'b0;
      rd_prev_q    <= 1'b1;
      data_q       <= '0;
      busy_q       <= 1'b0;
      first_q      <= 1'b0;
    end else begin
      cv_prev_q <= ad_convstab_i;
      rd_prev_q <= ad_rd_i;
      if (done) begin
        state_q      <= IDLE;
        busy_q       <= 1'b0;
        active_idx_q <= conv_idx_q;
        conv_idx_q   <= conv_idx_q + CNT_W'(1);
        ptr_q        <= fall ? 3'd1 : 3'd0;
        if (fall) begin
          data_q  <= {conv_idx_q, 3'd0};
          first_q <= 1'b1;
        end
      end else begin
        if (state_q == IDLE && rise) begin
          state_q <= CONV;
          busy_q  <= 1'b1;
          cnt_q   <= busy_len;
        end else if (state_q == CONV) begin
          cnt_q <= cnt_q - 14'd1;
        end
        if (fall) begin
          data_q  <= {active_idx_q, ptr_q};
          first_q <= (ptr_q == 3'd0);
          ptr_q   <= ptr_q + 3'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_ad7606_emulator.sv
// tb_ad7606_emulator: time-based reference model plus directed and random stimulus
module tb_ad7606_emulator;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  os = 3'd0;
  logic        cs = 1'b1;
  logic        rd = 1'b1;
  logic        ad_reset = 1'b0;
  logic        convst = 1'b0;
  logic [15:0] data;
  logic        busy;
  logic        first;
  int pass_cnt = 0;
  int total_cnt = 0;
  int busy_cycles = 0;
  int b0;
  // Reference model: conversion end is a point in time, reads index a published set
  int  cyc = 0;
  int  end_cyc = 0;
  int  conv_cnt = 0;
  int  active = 0;
  int  ptr = 0;
  bit  in_conv = 0;
  bit  p_cv = 0;
  bit  p_rd = 1;
  bit  m_rise, m_fall, m_done;
  int  os_eff;
  logic [15:0] e_data = 16'd0;
  bit  e_busy = 0;
  bit  e_first = 0;

  always #5 clk = ~clk;

  ad7606_emulator dut (
    .clk_i(clk), .rst_i(rst), .ad_os_i(os), .ad_cs_i(cs), .ad_rd_i(rd),
    .ad_reset_i(ad_reset), .ad_convstab_i(convst),
    .ad_data_o(data), .ad_busy_o(busy), .first_data_o(first)
  );

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  always @(posedge clk or posedge rst) begin
    cyc++;
    if (rst || ad_reset) begin
      in_conv = 0; conv_cnt = 0; active = 0; ptr = 0;
      e_data = 16'd0; e_busy = 0; e_first = 0; p_cv = 0; p_rd = 1;
    end else begin
      m_rise = convst && !p_cv;
      m_fall = p_rd && !rd && !cs;
      m_done = in_conv && (cyc == end_cyc);
      if (m_done) begin
        in_conv = 0;
        active = conv_cnt;
        conv_cnt = (conv_cnt + 1) % 8192;
        ptr = 0;
      end else if (!in_conv && m_rise) begin
        os_eff = (os == 3'd7) ? 0 : int'(os);
        in_conv = 1;
        end_cyc = cyc + (200 << os_eff);
      end
      if (m_fall) begin
        e_data = 16'(active * 8 + ptr);
        e_first = (ptr == 0);
        ptr = (ptr + 1) % 8;
      end
      e_busy = in_conv;
      p_cv = convst;
      p_rd = rd;
    end
  end

  always @(negedge clk) begin
    check("model_data", data, e_data);
    check("model_busy", busy, e_busy);
    check("model_first", first, e_first);
    busy_cycles += busy;
  end

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  task automatic rd_pulse(input logic c);
    cs = c;
    rd = 1'b0;
    tick;
    rd = 1'b1;
    tick;
  endtask

  task automatic wait_idle;
    for (int i = 0; i < 20000 && busy; i++) tick;
    check("idle_timeout", busy, 0);
  endtask

  task automatic conv(input logic [2:0] o, input int exp_len);
    b0 = busy_cycles;
    os = o;
    convst = 1'b1;
    tick;
    convst = 1'b0;
    wait_idle;
    check("busy_len", busy_cycles - b0, exp_len);
  endtask

  task automatic start_conv(input logic [2:0] o);
    os = o;
    convst = 1'b1;
    tick;
    convst = 1'b0;
  endtask

  initial begin
    repeat (3) tick;
    rst = 1'b0;
    tick;
    check("reset_data", data, 0);
    check("reset_busy", busy, 0);
    check("reset_first", first, 0);
    conv(3'd0, 200);
    for (int i = 0; i < 8; i++) begin
      rd_pulse(1'b0);
      check("read1_data", data, i);
      check("read1_first", first, (i == 0) ? 1 : 0);
    end
    rd_pulse(1'b0);
    check("wrap_data", data, 0);
    check("wrap_first", first, 1);
    rd_pulse(1'b1);
    rd_pulse(1'b1);
    check("cs_hold_data", data, 0);
    check("cs_hold_first", first, 1);
    rd_pulse(1'b0);
    check("cs_ptr_data", data, 1);
    check("cs_ptr_first", first, 0);
    conv(3'd3, 1600);
    for (int i = 0; i < 8; i++) begin
      rd_pulse(1'b0);
      check("read2_data", data, 8 + i);
      check("read2_first", first, (i == 0) ? 1 : 0);
    end
    conv(3'd7, 200);
    rd_pulse(1'b0);
    check("read3_data", data, 16'h0010);
    b0 = busy_cycles;
    start_conv(3'd0);
    repeat (48) tick;
    start_conv(3'd3);
    rd_pulse(1'b0);
    check("conv_read_data", data, 16'h0011);
    check("conv_read_busy", busy, 1);
    wait_idle;
    check("restart_len", busy_cycles - b0, 200);
    rd_pulse(1'b0);
    check("read4_data", data, 16'h0018);
    check("read4_first", first, 1);
    start_conv(3'd0);
    repeat (199) tick;
    cs = 1'b0;
    rd = 1'b0;
    tick;
    check("collide_data", data, 16'h0020);
    check("collide_first", first, 1);
    check("collide_busy", busy, 0);
    rd = 1'b1;
    tick;
    rd_pulse(1'b0);
    check("collide_next", data, 16'h0021);
    start_conv(3'd0);
    repeat (99) tick;
    check("pre_abort_busy", busy, 1);
    ad_reset = 1'b1;
    tick;
    check("soft_rst_busy", busy, 0);
    check("soft_rst_data", data, 0);
    check("soft_rst_first", first, 0);
    ad_reset = 1'b0;
    tick;
    conv(3'd0, 200);
    rd_pulse(1'b0);
    check("fresh_data", data, 0);
    check("fresh_first", first, 1);
    start_conv(3'd0);
    repeat (20) tick;
    rd_pulse(1'b0);
    check("pre_arst_data", data, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_data", data, 0);
    tick;
    rst = 1'b0;
    tick;
    for (int i = 0; i < 6000; i++) begin
      tick;
      convst = ($urandom % 40 == 0);
      case ($urandom % 3)
        0: os = 3'd0;
        1: os = 3'd1;
        default: os = 3'd7;
      endcase
      cs = ($urandom % 4 == 0);
      rd = $urandom % 2;
      ad_reset = ($urandom % 700 == 0);
    end
    ad_reset = 1'b0;
    tick;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
